// File: rtl/alu_bist.sv
// alu_bist: built-in self-test engine for the WIDTH-bit combinational ALU.
// It sweeps every {ALU_Sel, A, B} vector onto the ALU inputs and holds each one
// for SETTLE cycles. It then samples ALU_Out and compares it with an internal
// golden model. At the end it reports pass/fail, the mismatch count and the
// first failing vector.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   start       one-cycle pulse; begins a full sweep (ignored while busy)
//   A, B        ALU operands (fields of the current vector)
//   ALU_Sel     ALU operation select (most significant field of the vector)
//   ALU_Out     ALU result fed back for checking
//   busy        high while a sweep is in progress
//   done        high from sweep end until the next start or reset
//   pass        valid with done: 1 = no mismatches seen
//   err_count   saturating mismatch count
//   first_fail  vector index {ALU_Sel, A, B} of the first mismatch
module alu_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [1:0]           ALU_Sel,
  input  logic [WIDTH-1:0]     ALU_Out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+2:0]   err_count,
  output logic [2*WIDTH+1:0]   first_fail
);

  localparam int VW = 2*WIDTH + 2;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [VW-1:0]      V_LAST      = '1;
  localparam logic [2*WIDTH+2:0] ERR_MAX     = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [VW-1:0]   v;
  logic [SW-1:0]   settle_cnt;
  logic [WIDTH-1:0] golden;
  logic            mismatch;

  // The stimulus is the vector register itself, so it holds in IDLE and DONE
  // without extra storage.
  assign ALU_Sel = v[VW-1:VW-2];
  assign A       = v[2*WIDTH-1:WIDTH];
  assign B       = v[WIDTH-1:0];

  always_comb begin
    golden = '0;
    unique case (ALU_Sel)
      2'b00: golden = A + B;
      2'b01: golden = A - B;
      2'b10: golden = A * B;
      2'b11: golden = (B == '0) ? '0 : A / B;
      default: golden = '0;
    endcase
  end

  assign mismatch = (ALU_Out != golden);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v          <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            v          <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            // err_count saturates and never returns to zero mid-sweep, so zero
            // identifies the first mismatch.
            if (err_count == '0) first_fail <= v;
          end
          if (v == V_LAST) begin
            // Fold the last sample into pass, since err_count updates on this same edge.
            pass  <= (err_count == '0) && !mismatch;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            v     <= v + 1'b1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Testbench for alu_bist. A behavioural ALU with selectable faults is wired
// back to the BIST engine. Each sweep pushes its expected summary into a queue.
// A monitor pops that entry when done rises and compares pass, err_count,
// first_fail and the number of busy cycles.
module tb_alu_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  a, b;
  logic [1:0]  alu_sel;
  logic [3:0]  alu_out;
  logic        busy, done, pass;
  logic [10:0] err_count;
  logic [9:0]  first_fail;

  // 0 correct ALU, 1 sub stuck as add, 2 output stuck at zero,
  // 3 divide-by-zero returns 4'hF instead of 0
  int mode = 0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        pass;
    logic [10:0] err;
    logic [9:0]  ff;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_bist #(.WIDTH(4), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (a),
    .B         (b),
    .ALU_Sel   (alu_sel),
    .ALU_Out   (alu_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .first_fail(first_fail)
  );

  always_comb begin
    alu_out = 4'h0;
    case (alu_sel)
      2'b00: alu_out = a + b;
      2'b01: alu_out = (mode == 1) ? a + b : a - b;
      2'b10: alu_out = a * b;
      2'b11: alu_out = (b == 4'h0) ? ((mode == 3) ? 4'hF : 4'h0) : a / b;
      default: alu_out = 4'h0;
    endcase
    if (mode == 2) alu_out = 4'h0;
  end

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: compares each completed sweep against the queued expectation.
  int   busy_cyc = 0;
  logic done_q   = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cyc = 0;
        done_q   = 1'b0;
      end else begin
        if (busy) busy_cyc++;
        if (done && !done_q) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pass",       int'(pass),       int'(e.pass));
            check("err_count",  int'(err_count),  int'(e.err));
            check("first_fail", int'(first_fail), int'(e.ff));
            check("busy_cycles", busy_cyc,        e.cyc);
          end
          busy_cyc = 0;
        end
        done_q = done;
      end
    end
  end

  task automatic expect_sweep(input logic p, input int err, input int ff);
    exp_t e;
    e.pass = p;
    e.err  = 11'(err);
    e.ff   = 10'(ff);
    e.cyc  = 2048;
    exp_q.push_back(e);
  endtask

  // start is sampled on the second edge; the caller resumes 1 time unit after it
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},       int'(busy),                   0);
    check({tag, "_done"},       int'(done),                   0);
    check({tag, "_pass"},       int'(pass),                   0);
    check({tag, "_err_count"},  int'(err_count),              0);
    check({tag, "_first_fail"}, int'(first_fail),             0);
    check({tag, "_stimulus"},   int'({alu_sel, a, b}),        0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    rst = 1'b0;

    // Correct ALU: a clean sweep
    mode = 0;
    expect_sweep(1'b1, 0, 0);
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    wait_done();
    check("stim_holds_last", int'({alu_sel, a, b}), 10'h3FF);

    // Sub stuck as add: a-b equals a+b mod 16 only for b=0 and b=8 -> 16*14
    mode = 1;
    expect_sweep(1'b0, 224, 10'h101);
    pulse_start();
    wait_done();

    // Restart from DONE clears results at once; a start at cycle 500 is ignored
    mode = 0;
    expect_sweep(1'b1, 0, 0);
    pulse_start();
    check("restart_done_low",  int'(done),       0);
    check("restart_err_clear", int'(err_count),  0);
    check("restart_ff_clear",  int'(first_fail), 0);
    check("restart_busy",      int'(busy),       1);
    repeat (498) @(posedge clk);
    pulse_start();
    check("busy_after_ignored_start", int'(busy), 1);
    wait_done();

    // Output stuck at zero: nonzero golden results add 240+240+208+120
    mode = 2;
    expect_sweep(1'b0, 808, 10'h001);
    pulse_start();
    wait_done();

    // Divide by zero must expect 0: returning F there fails the 16 vectors
    // including 0x3A0, and the first is 0x300
    mode = 3;
    expect_sweep(1'b0, 16, 10'h300);
    pulse_start();
    wait_done();

    // Reset mid-sweep discards everything; a later sweep is clean
    mode = 1;
    pulse_start();
    repeat (999) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midrst");
    rst  = 1'b0;
    repeat (3) @(posedge clk);
    check("idle_stays_idle", int'(busy), 0);
    mode = 0;
    expect_sweep(1'b1, 0, 0);
    pulse_start();
    wait_done();

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
